stats_scan_ctrl: RTL and testbench

Sequencing and compare stage directly upstream of the MAX/MIN/AVG result registers. It accepts a run of `len` unsigned samples over a valid/ready stream and compares each sample against the current contents of the max and min registers. It drives their data/load pairs (`Max_in`/`Max_load` style) and, optionally, computes the rounded-down average through a sequential divider. Busy/done handshake to the ASIP control unit.

---
 rtl/stats_pkg.sv | 15 +
 rtl/stats_scan_ctrl_if.sv | 13 +
 rtl/stats_divider.sv | 59 +++++
 rtl/stats_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_stats_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stats_pkg.sv
// Shared types and default widths for the stats scan/compare slice.
package stats_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SUM_W  = DATA_W + CNT_W;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/stats_scan_ctrl_if.sv
// Valid/ready sample stream into the stats scan controller.
interface stats_scan_ctrl_if #(
    parameter int unsigned DATA_W = 8
);

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/stats_divider.sv
// Sequential restoring divider: one quotient bit per cycle, DVD_W cycles per divide.
module stats_divider #(
    parameter int unsigned DVD_W = 16,
    parameter int unsigned DVS_W = 8,
    parameter int unsigned Q_W   = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             go,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             q_valid,
    output logic [Q_W-1:0]   quotient
);

    localparam int unsigned CW = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem;
    logic [DVD_W-1:0] quo;
    logic [CW-1:0]    left;
    logic [DVS_W:0]   trial;
    logic             fits;
    logic [DVS_W-1:0] rem_next;
    logic [DVD_W-1:0] quo_next;

    // Remainder stays below the divisor, so DVS_W+1 bits hold every trial value.
    always_comb begin
        trial    = {rem, quo[DVD_W-1]};
        fits     = (trial >= {1'b0, divisor});
        rem_next = fits ? DVS_W'(trial - {1'b0, divisor}) : trial[DVS_W-1:0];
        quo_next = {quo[DVD_W-2:0], fits};
    end

    // Quotient is presented combinationally during the final iteration.
    assign q_valid  = busy && (left == CW'(1));
    assign quotient = quo_next[Q_W-1:0];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rem  <= '0;
            quo  <= '0;
            left <= '0;
            busy <= 1'b0;
        end else if (go && !busy) begin
            rem  <= '0;
            quo  <= dividend;
            left <= CW'(DVD_W);
            busy <= 1'b1;
        end else if (busy) begin
            rem  <= rem_next;
            quo  <= quo_next;
            left <= left - CW'(1);
            if (left == CW'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/stats_scan_ctrl.sv
// Max/min compare and run sequencing for the stats result registers.
// Define STATS_AVG_EN to build the accumulator and divider for avg_out.
module stats_scan_ctrl #(
    parameter int unsigned DATA_W = stats_pkg::DATA_W,
    parameter int unsigned CNT_W  = stats_pkg::CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    stats_scan_ctrl_if.slave  s_if,
    input  logic [DATA_W-1:0] max_cur,
    input  logic [DATA_W-1:0] min_cur,
    output logic [DATA_W-1:0] max_next,
    output logic              max_load,
    output logic [DATA_W-1:0] min_next,
    output logic              min_load,
    output logic [DATA_W-1:0] avg_out,
    output logic              busy,
    output logic              done
);

    import stats_pkg::*;

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt;
    logic             first;
    logic             ready_q;
    logic             xfer;
    logic             last;

    assign s_if.s_ready = ready_q;
    assign xfer         = s_if.s_valid & ready_q;
    assign last         = xfer && (cnt == len_q - CNT_W'(1));

    // Zero-latency compare so the result registers load on the transfer edge.
    always_comb begin
        max_next = '0;
        min_next = '0;
        max_load = 1'b0;
        min_load = 1'b0;
        if (xfer) begin
            max_next = s_if.s_data;
            min_next = s_if.s_data;
            max_load = first | (s_if.s_data > max_cur);
            min_load = first | (s_if.s_data < min_cur);
        end
    end

`ifdef STATS_AVG_EN
    localparam int unsigned SUM_W = DATA_W + CNT_W;

    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;
    logic              div_busy;
    logic              q_valid;
    logic [DATA_W-1:0] quot;

    assign sum_next = sum + SUM_W'(s_if.s_data);

    // Divider starts on the last transfer with the sum including that sample.
    stats_divider #(
        .DVD_W (SUM_W),
        .DVS_W (CNT_W),
        .Q_W   (DATA_W)
    ) u_div (
        .CLK      (CLK),
        .RESET    (RESET),
        .go       (last),
        .dividend (sum_next),
        .divisor  (len_q),
        .busy     (div_busy),
        .q_valid  (q_valid),
        .quotient (quot)
    );
`else
    assign avg_out = '0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            len_q   <= '0;
            cnt     <= '0;
            first   <= 1'b0;
            ready_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef STATS_AVG_EN
            sum     <= '0;
            avg_out <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            len_q   <= len;
                            cnt     <= '0;
                            first   <= 1'b1;
                            ready_q <= 1'b1;
                            state   <= SCAN;
`ifdef STATS_AVG_EN
                            sum     <= '0;
`endif
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
`ifdef STATS_AVG_EN
                            avg_out <= '0;
`endif
                        end
                    end
                end
                SCAN: begin
                    if (xfer) begin
                        cnt   <= cnt + CNT_W'(1);
                        first <= 1'b0;
`ifdef STATS_AVG_EN
                        sum   <= sum_next;
`endif
                        if (last) begin
                            ready_q <= 1'b0;
`ifdef STATS_AVG_EN
                            state   <= DIV;
`else
                            state   <= DONE;
                            done    <= 1'b1;
`endif
                        end
                    end
                end
                DIV: begin
`ifdef STATS_AVG_EN
                    if (div_busy && q_valid) begin
                        avg_out <= quot;
                        state   <= DONE;
                        done    <= 1'b1;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stats_scan_ctrl.sv
// Directed bench for stats_scan_ctrl with a load-strobe scoreboard and result register models.
module tb_stats_scan_ctrl;

`ifdef STATS_AVG_EN
    localparam int AVG_ON   = 1;
    localparam int DONE_LAT = 17;
`else
    localparam int AVG_ON   = 0;
    localparam int DONE_LAT = 1;
`endif

    typedef struct packed {
        logic       ml;
        logic       nl;
        logic [7:0] d;
    } exp_t;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len   = '0;
    logic [7:0] max_next, min_next, avg_out;
    logic       max_load, min_load, busy, done;
    logic [7:0] max_reg = '0;
    logic [7:0] min_reg = '0;

    stats_scan_ctrl_if #(.DATA_W(8)) sif ();

    stats_scan_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .len      (len),
        .s_if     (sif),
        .max_cur  (max_reg),
        .min_cur  (min_reg),
        .max_next (max_next),
        .max_load (max_load),
        .min_next (min_next),
        .min_load (min_load),
        .avg_out  (avg_out),
        .busy     (busy),
        .done     (done)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    int   done_cnt = 0;
    int   done_base = 0;
    int   done_cyc = 0;
    int   last_xfer_cyc = 0;
    bit   spur = 1'b0;
    exp_t sb[$];
    logic [7:0] smp [0:254];
    int   gap [0:254];

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc_n++;

    // Downstream MAX/MIN registers driven by the DUT's load strobes
    always @(posedge CLK) begin
        if (max_load) max_reg <= max_next;
        if (min_load) min_reg <= min_next;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        #3;
        if (RESET) begin
            if (sif.s_valid && sif.s_ready) begin
                last_xfer_cyc = cyc_n;
                chk("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("max_load", max_load, e.ml);
                    chk("min_load", min_load, e.nl);
                    chk("max_next", max_next, e.d);
                    chk("min_next", min_next, e.d);
                end
            end else begin
                chk("idle_strobes", {max_load, min_load, max_next, min_next}, 0);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc_n;
            end
        end
    end

    task automatic finish_run(input int ref_cyc, input int lat, input int exp_avg);
        int k;
        k = 0;
        while (done_cnt == done_base && k < 64) begin
            tick;
            #4;
            k++;
        end
        chk("done_pulses", done_cnt - done_base, 1);
        chk("done_latency", done_cyc - ref_cyc, lat);
        chk("sb_empty", sb.size(), 0);
        chk("avg_out", avg_out, exp_avg);
        tick;
        #4;
        chk("busy_after", busy, 0);
    endtask

    task automatic run(input int n, input int exp_avg);
        logic [7:0] rmax, rmin;
        exp_t e;
        int s_cyc, ref_cyc;
        rmax = '0;
        rmin = '0;
        done_base = done_cnt;
        tick;
        start = 1'b1;
        len   = n[7:0];
        s_cyc = cyc_n;
        tick;
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < gap[k]; g++) begin
                sif.s_valid = 1'b0;
                if (spur) begin
                    start = 1'b1;
                    len   = 8'd9;
                end
                tick;
                start = 1'b0;
                len   = n[7:0];
            end
            sif.s_valid = 1'b1;
            sif.s_data  = smp[k];
            e.ml = (k == 0) || (smp[k] > rmax);
            e.nl = (k == 0) || (smp[k] < rmin);
            e.d  = smp[k];
            if (e.ml) rmax = smp[k];
            if (e.nl) rmin = smp[k];
            sb.push_back(e);
            tick;
        end
        sif.s_valid = 1'b0;
        ref_cyc = (n == 0) ? s_cyc : last_xfer_cyc;
        if (spur) begin
            start = 1'b1;
            len   = 8'd200;
            tick;
            start = 1'b0;
            len   = n[7:0];
        end
        finish_run(ref_cyc, (n == 0) ? 1 : DONE_LAT, exp_avg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        #12;
        chk("rst_s_ready", sif.s_ready, 0);
        chk("rst_loads", {max_load, min_load}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_next", {max_next, min_next}, 0);
        chk("rst_avg", avg_out, 0);
        tick;
        RESET = 1'b1;

        // Reset after 2 of 5 samples discards the run
        done_base = done_cnt;
        tick; start = 1'b1; len = 8'd5;
        tick; start = 1'b0;
        sif.s_valid = 1'b1; sif.s_data = 8'd20; sb.push_back('{1'b1, 1'b1, 8'd20}); tick;
        sif.s_valid = 1'b1; sif.s_data = 8'd30; sb.push_back('{1'b1, 1'b0, 8'd30}); tick;
        sif.s_data = 8'd77;
        RESET = 1'b0;
        #2;
        chk("mid_rst_s_ready", sif.s_ready, 0);
        chk("mid_rst_loads", {max_load, min_load}, 0);
        chk("mid_rst_next", {max_next, min_next}, 0);
        chk("mid_rst_busy_done", {busy, done}, 0);
        chk("mid_rst_avg", avg_out, 0);
        chk("mid_rst_sb", sb.size(), 0);
        tick;
        RESET = 1'b1;
        sif.s_valid = 1'b0;
        tick;
        #4;
        chk("post_rst_idle", {busy, sif.s_ready}, 0);
        chk("post_rst_no_done", done_cnt - done_base, 0);

        smp[0] = 8'd9; gap[0] = 0;
        run(1, AVG_ON ? 9 : 0);
        chk("r1_max", max_reg, 9);
        chk("r1_min", min_reg, 9);

        smp[0] = 8'd10; smp[1] = 8'd40; smp[2] = 8'd40; smp[3] = 8'd5;
        for (int i = 0; i < 4; i++) gap[i] = 0;
        run(4, AVG_ON ? 23 : 0);
        chk("r4_max", max_reg, 40);
        chk("r4_min", min_reg, 5);

        smp[0] = 8'd200; smp[1] = 8'd255; smp[2] = 8'd0;
        gap[0] = 0; gap[1] = 3; gap[2] = 1;
        run(3, AVG_ON ? 151 : 0);
        chk("r3_max", max_reg, 255);
        chk("r3_min", min_reg, 0);

        run(0, 0);
        chk("r0_max_kept", max_reg, 255);
        chk("r0_min_kept", min_reg, 0);

        smp[0] = 8'd3; smp[1] = 8'd7; gap[0] = 0; gap[1] = 1;
        spur = 1'b1;
        run(2, AVG_ON ? 5 : 0);
        spur = 1'b0;
        chk("spur_max", max_reg, 7);
        chk("spur_min", min_reg, 3);

        for (int i = 0; i < 255; i++) begin
            smp[i] = 8'd255;
            gap[i] = 0;
        end
        run(255, AVG_ON ? 255 : 0);
        chk("r255_max", max_reg, 255);
        chk("r255_min", min_reg, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
